// File: rtl/alu_result_fifo.sv
// Result buffer behind the ALU: tags each result with its op and status flags
// and holds it in a first-word-fall-through FIFO with valid/ready on both sides.
module alu_result_fifo #(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  s,
    input  logic          co,
    input  logic [2:0]    sel,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_s,
    output logic          out_c,
    output logic          out_z,
    output logic          out_neg,
    output logic [2:0]    out_sel,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [N-1:0] s;
        logic         c;
        logic         z;
        logic         neg;
        logic [2:0]   sel;
    } entry_t;

    // Carry is only meaningful for the arithmetic ops (ADD, SUB, INR, DCR).
    function automatic entry_t make_entry(input logic [N-1:0] s_i, input logic co_i,
                                          input logic [2:0] sel_i);
        entry_t e;
        e.s   = s_i;
        e.z   = (s_i == '0);
        e.neg = s_i[N-1];
        e.sel = sel_i;
        case (sel_i)
            3'd0, 3'd1, 3'd2, 3'd3: e.c = co_i;
            default:                e.c = 1'b0;
        endcase
        return e;
    endfunction

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            push_s;
    logic            pop_s;
    entry_t          head_s;

    assign push_s    = in_valid && !full_q;
    assign pop_s     = out_ready && !empty_q;
    assign in_ready  = !full_q;
    assign out_valid = !empty_q;
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;

    // Next-state for pointers, occupancy and the registered full/empty flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            mem_q[wr_ptr_q] <= make_entry(s, co, sel);
        end
    end

    // Head entry falls through to the outputs, forced to zero while empty.
    always_comb begin
        head_s = mem_q[rd_ptr_q];
        if (empty_q) begin
            out_s   = '0;
            out_c   = 1'b0;
            out_z   = 1'b0;
            out_neg = 1'b0;
            out_sel = 3'd0;
        end else begin
            out_s   = head_s.s;
            out_c   = head_s.c;
            out_z   = head_s.z;
            out_neg = head_s.neg;
            out_sel = head_s.sel;
        end
    end

endmodule
